ram_ctrl: RTL
=============

# ram_ctrl

Request/response front end for the single-port RAM (`ram_sp`). Accepts read/write commands on a valid/ready channel and drives the RAM's active-low `cen`/`wen`, `addr` and `din` pins. It captures the RAM's one-cycle-late `dout` into a 3-entry response FIFO, so read data is returned on a valid/ready channel with full throughput under backpressure. Sits directly upstream of `ram_sp`: one `ram_ctrl` per RAM instance.

## Interface

- WIDTH, 8, data width; must match the RAM.
- DEPTH, 256, number of RAM words; address width AW = $clog2(DEPTH).

- clk  in  1  clock, shared with the RAM.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when `req_valid && req_ready`.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  AW  word address.
- req_wdata  in  WIDTH  write data.
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  consumer ready.
- rsp_rdata  out  WIDTH  read data, returned in request order.
- init_done  out  1  high when commands may be accepted.
- ram_cen  out  1  to RAM `cen`, active low.
- ram_wen  out  1  to RAM `wen`, active low.
- ram_addr  out  AW  to RAM `addr`.
- ram_din  out  WIDTH  to RAM `din`.
- ram_dout  in  WIDTH  from RAM `dout`.

## Operation

- State: `run` flag (plus INIT state if configured); `rd_pending` (1 bit, a read issued last cycle); 3-entry first-word-fall-through FIFO with `count` 0..3.
- `req_ready = run && (count + rd_pending < 3)`. It is independent of `req_we`, `req_valid` and `rsp_ready`.
- Accept (fire) drives RAM the same cycle, combinationally:
  - `ram_cen = 0`, `ram_wen = !req_we`, `ram_addr = req_addr`, `ram_din = req_wdata`.
- No fire: `ram_cen = 1`, `ram_wen = 1`, `ram_addr = 0`, `ram_din = 0`.
- Read fire sets `rd_pending` at the next edge. In the following cycle `ram_dout` is pushed into the FIFO tail.
- `rsp_valid = (count != 0)`; `rsp_rdata` = FIFO head. Pop on `rsp_valid && rsp_ready`.
- Push and pop may occur in the same cycle; `count` is then unchanged.
- The gating guarantees a push never meets a full FIFO. Overflow is impossible by construction, and the bench asserts it.
- Writes produce no response.
- Write followed by read of the same address in the next cycle returns the new data. The RAM orders this naturally.

## Timing

- Read accepted in cycle t → `rsp_valid` first high in cycle t+2 if the FIFO is empty.
- Sustained 1 read/cycle when `rsp_ready` is held high. Steady state is `count = 1`, `rd_pending = 1`.
- With `rsp_ready` low, at most 3 reads are outstanding; `req_ready` then stays low until a pop.
- `req_ready` recovers the cycle after a pop, with no combinational `rsp_ready → req_ready` path.
- Reset (async assert, any cycle), all of the following:
  - `req_ready = 0`, `rsp_valid = 0`, `rsp_rdata = 0` (FIFO storage cleared), `count = 0`, `rd_pending = 0`.
  - `ram_cen = 1`, `ram_wen = 1`, `ram_addr = 0`, `ram_din = 0`.
  - In-flight read data is discarded; RAM contents are untouched.
- After reset release (macro off): `run = 1`, `init_done = 1`, and `req_ready = 1` from the first cycle.

## Configuration

- `RAM_CTRL_INIT_EN` defined: post-reset clear.
  - Reset enters INIT with `run = 0` and `init_done = 0`.
  - In INIT, each cycle drives `ram_cen = 0`, `ram_wen = 0`, `ram_addr = init_cnt`, `ram_din = 0`. `init_cnt` counts 0..DEPTH-1.
  - After the write of DEPTH-1 the state moves to RUN. `init_done` and `req_ready` rise in the cycle after that write, i.e. DEPTH cycles after reset release.
  - Reset mid-INIT restarts from address 0.
- Undefined: no INIT state and no `init_cnt`. `init_done` is constant 1 outside reset, and RUN is entered immediately.

## Test plan

- Write 0xA5 to addr 0x10, then read 0x10 next cycle → `rsp_valid` two cycles after the read fire with `rsp_rdata = 0xA5`.
- Write addrs 0..7 with data addr+0x40, then 8 back-to-back reads with `rsp_ready = 1` → `req_ready` never drops; responses 0x40..0x47 on 8 consecutive cycles, in order.
- `rsp_ready = 0`, issue reads continuously → exactly 3 fires, then `req_ready = 0` with `count = 3`. Raise `rsp_ready` → 3 responses drained in order, and `req_ready` returns the cycle after the first pop.
- Assert `rst_n` low the cycle after a read fire → no response ever appears; all outputs at reset values. The next read of the same address returns the stored data.
- `RAM_CTRL_INIT_EN`, DEPTH = 16: fill RAM with 0xFF, then pulse reset → `init_done` low for 16 cycles while addrs 0..15 are written with 0. Then `init_done = 1`, and a read of addr 15 returns 0x00.

Source files
------------

// File: rtl/ram_ctrl.sv
// ram_ctrl: valid/ready command front end for ram_sp with a 3-entry read response FIFO.
// Define RAM_CTRL_INIT_EN to zero every RAM word after each reset before accepting commands.
module ram_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             init_done,
    output logic             ram_cen,
    output logic             ram_wen,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_din,
    input  logic [WIDTH-1:0] ram_dout
);

    logic             run;
    logic             init_active;
    logic [AW-1:0]    init_addr;
    logic             fire;
    logic             rd_pending;
    logic             push;
    logic             pop;
    logic [1:0]       count;
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [2:0]       occupancy;
    logic [WIDTH-1:0] fifo_mem [3];

`ifdef RAM_CTRL_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] init_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + AW'(1);
            end
        end
    end

    // INIT drive is gated by rst_n so the RAM pins stay idle while reset is held.
    always_comb begin
        state_next  = state;
        run         = 1'b0;
        init_active = 1'b0;
        case (state)
            ST_INIT: begin
                init_active = rst_n;
                if (init_cnt == AW'(DEPTH - 1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                run = 1'b1;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    assign init_addr = init_cnt;
    assign init_done = run;
`else
    assign run         = rst_n;
    assign init_active = 1'b0;
    assign init_addr   = '0;
    assign init_done   = rst_n;
`endif

    // Gating counts the read still in the RAM pipe so a push never meets a full FIFO.
    assign occupancy = {1'b0, count} + {2'b00, rd_pending};
    assign req_ready = run && (occupancy < 3'd3);
    assign fire      = req_valid && req_ready;
    assign push      = rd_pending;
    assign rsp_valid = (count != 2'd0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_rdata = fifo_mem[rd_ptr];

    always_comb begin
        ram_cen  = 1'b1;
        ram_wen  = 1'b1;
        ram_addr = '0;
        ram_din  = '0;
        if (init_active) begin
            ram_cen  = 1'b0;
            ram_wen  = 1'b0;
            ram_addr = init_addr;
        end else if (fire) begin
            ram_cen  = 1'b0;
            ram_wen  = !req_we;
            ram_addr = req_addr;
            ram_din  = req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending <= 1'b0;
            count      <= 2'd0;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            rd_pending <= fire && !req_we;
            if (push) begin
                fifo_mem[wr_ptr] <= ram_dout;
                wr_ptr           <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
